// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational 32-bit ALU between two requesters. Requests are
//   granted round-robin over valid/ready handshakes; the result, {V,C,Z,S}
//   flags, source port, tag and error bit are registered in one output stage
//   and returned over a valid/ready result channel.
//
// Optional feature macro: ALU_DIVZERO_TRAP_EN
//   defined     : div/mod by zero raises res_err with res_data 0, flags 4'b0010
//   not defined : res_err is tied 0
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req{0,1}_valid/_ready      request handshake per port
//   req{0,1}_a/_b              signed 32-bit operands
//   req{0,1}_op                0 add,1 sub,2 mul,3 div,4 and,5 or,6 xor,7 mod
//   req{0,1}_tag               opaque tag returned with the result
//   res_valid/res_ready        result handshake
//   res_data, res_flags        result and {V,C,Z,S}
//   res_src, res_tag, res_err  granted port, its tag, divide-by-zero error
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [3:0]       res_flags,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_MOD = 3'd7;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic rr;          // preferred port when both are valid
    logic can_accept;
    logic grant0, grant1;

    // ALU-side view of the granted port (port 0 when idle, result unused then)
    logic [31:0]      alu_a, alu_b;
    logic [2:0]       alu_op;
    logic [TAG_W-1:0] alu_tag;

    logic [31:0] alu_res;
    logic        alu_v, alu_c, alu_err, div_zero;
    logic [32:0] sum33;

    assign can_accept = !res_valid || res_ready;

    // rst gates the grants so a request seen in a reset cycle is not consumed
    assign grant0 = !rst && can_accept && req0_valid && (!req1_valid || !rr);
    assign grant1 = !rst && can_accept && req1_valid && (!req0_valid ||  rr);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign alu_a   = grant1 ? req1_a   : req0_a;
    assign alu_b   = grant1 ? req1_b   : req0_b;
    assign alu_op  = grant1 ? req1_op  : req0_op;
    assign alu_tag = grant1 ? req1_tag : req0_tag;

    assign div_zero = (alu_op == OP_DIV || alu_op == OP_MOD) && (alu_b == 32'd0);

    always_comb begin
        alu_res = 32'd0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        sum33   = 33'd0;
        case (alu_op)
            OP_ADD: begin
                sum33   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res = sum33[31:0];
                alu_c   = sum33[32];
                alu_v   = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            OP_SUB: begin
                alu_res = alu_a - alu_b;
                // C is a borrow: set when a < b as unsigned values
                alu_c   = alu_a < alu_b;
                alu_v   = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            OP_MUL: alu_res = alu_a * alu_b;  // low 32 bits are sign-agnostic
            OP_DIV: begin
                // zero divisor forced to 0 to keep X out of the datapath;
                // INT_MIN / -1 wraps to INT_MIN
                if (alu_b == 32'd0)
                    alu_res = 32'd0;
                else if (alu_a == INT_MIN && alu_b == 32'hFFFF_FFFF)
                    alu_res = INT_MIN;
                else
                    alu_res = $signed(alu_a) / $signed(alu_b);
            end
            OP_MOD: begin
                if (alu_b == 32'd0 || (alu_a == INT_MIN && alu_b == 32'hFFFF_FFFF))
                    alu_res = 32'd0;
                else
                    alu_res = $signed(alu_a) % $signed(alu_b);
            end
            OP_AND: alu_res = alu_a & alu_b;
            OP_OR:  alu_res = alu_a | alu_b;
            OP_XOR: alu_res = alu_a ^ alu_b;
            default: alu_res = 32'd0;
        endcase
    end

`ifdef ALU_DIVZERO_TRAP_EN
    assign alu_err = div_zero;
`else
    assign alu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= 32'd0;
            res_flags <= 4'd0;
            res_src   <= 1'b0;
            res_tag   <= '0;
            res_err   <= 1'b0;
            rr        <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                res_valid <= 1'b1;
                res_src   <= grant1;
                res_tag   <= alu_tag;
                res_err   <= alu_err;
                if (alu_err) begin
                    res_data  <= 32'd0;
                    res_flags <= 4'b0010;
                end else begin
                    res_data  <= alu_res;
                    res_flags <= {alu_v, alu_c, (alu_res == 32'd0), alu_res[31]};
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            // pointer moves only on contended grants, away from the winner
            if (req0_valid && req1_valid && (grant0 || grant1))
                rr <= grant0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [31:0]      req0_a, req0_b;
    logic [2:0]       req0_op;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready;
    logic [31:0]      req1_a, req1_b;
    logic [2:0]       req1_op;
    logic [TAG_W-1:0] req1_tag;
    logic             res_valid, res_ready;
    logic [31:0]      res_data;
    logic [3:0]       res_flags;
    logic             res_src;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags), .res_src(res_src),
        .res_tag(res_tag), .res_err(res_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".rdy0"}, {31'd0, req0_ready}, {31'd0, r0});
        chk({tag, ".rdy1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    task automatic chk_res(input string tag, input logic v, input logic [31:0] d,
                           input logic [3:0] f, input logic s, input logic [3:0] t);
        chk({tag, ".valid"}, {31'd0, res_valid}, {31'd0, v});
        chk({tag, ".data"},  res_data, d);
        chk({tag, ".flags"}, {28'd0, res_flags}, {28'd0, f});
        chk({tag, ".src"},   {31'd0, res_src}, {31'd0, s});
        chk({tag, ".tag"},   {28'd0, res_tag}, {28'd0, t});
    endtask

    task automatic chk_err(input string tag, input logic e);
        chk({tag, ".err"}, {31'd0, res_err}, {31'd0, e});
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] t);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_tag = t;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] t);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_tag = t;
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b1;
        set0(1'b1, 32'd1, 32'd1, 3'd0, 4'd9);   // request during reset: not granted
        set1(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);

        // ---- reset state ----
        tick();
        tick();
        #1 chk_rdy("rst", 1'b0, 1'b0);
        chk_res("rst", 1'b0, 32'd0, 4'b0000, 1'b0, 4'd0);
        chk_err("rst", 1'b0);

        // ---- first request: add 5+7 ----
        rst = 1'b0;
        set0(1'b1, 32'd5, 32'd7, 3'd0, 4'd3);
        #1 chk_rdy("add", 1'b1, 1'b0);
        tick();
        chk_res("add", 1'b1, 32'd12, 4'b0000, 1'b0, 4'd3);
        chk_err("add", 1'b0);

        // ---- drain with no new grant: valid drops, data holds ----
        set0(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
        tick();
        chk_res("drain", 1'b0, 32'd12, 4'b0000, 1'b0, 4'd3);

        // ---- contention: alternating grants ----
        set0(1'b1, 32'd3, 32'd3, 3'd1, 4'd1);
        set1(1'b1, 32'h7FFF_FFFF, 32'd1, 3'd0, 4'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i % 2 == 0) begin
                chk_rdy("rr0", 1'b1, 1'b0);
                tick();
                chk_res("rr0", 1'b1, 32'd0, 4'b0010, 1'b0, 4'd1);
            end else begin
                chk_rdy("rr1", 1'b0, 1'b1);
                tick();
                chk_res("rr1", 1'b1, 32'h8000_0000, 4'b1001, 1'b1, 4'd2);
            end
        end

        // ---- backpressure: held result, no readies ----
        res_ready = 1'b0;
        #1 chk_rdy("bp", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_rdy("bp", 1'b0, 1'b0);
            chk_res("bp", 1'b1, 32'h8000_0000, 4'b1001, 1'b1, 4'd2);
        end
        // release: same-cycle refill, rr still points at port 0
        res_ready = 1'b1;
        #1 chk_rdy("refill", 1'b1, 1'b0);
        tick();
        chk_res("refill", 1'b1, 32'd0, 4'b0010, 1'b0, 4'd1);
        #1 chk_rdy("refill2", 1'b0, 1'b1);
        tick();
        chk_res("refill2", 1'b1, 32'h8000_0000, 4'b1001, 1'b1, 4'd2);

        // ---- single requester on port 1 ----
        set0(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
        set1(1'b1, 32'hFFFF_FFFD, 32'd4, 3'd2, 4'd4);       // -3 * 4
        #1 chk_rdy("mul", 1'b0, 1'b1);
        tick();
        chk_res("mul", 1'b1, 32'hFFFF_FFF4, 4'b0001, 1'b1, 4'd4);
        set1(1'b1, 32'hF0F0_1234, 32'hFF00_FF00, 3'd4, 4'd5);
        #1 chk_rdy("and", 1'b0, 1'b1);
        tick();
        chk_res("and", 1'b1, 32'hF000_1200, 4'b0001, 1'b1, 4'd5);
        set1(1'b1, 32'h0000_00F0, 32'h0000_000F, 3'd5, 4'd6);
        #1 chk_rdy("or", 1'b0, 1'b1);
        tick();
        chk_res("or", 1'b1, 32'h0000_00FF, 4'b0000, 1'b1, 4'd6);
        set1(1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 3'd6, 4'd7);
        #1 chk_rdy("xor", 1'b0, 1'b1);
        tick();
        chk_res("xor", 1'b1, 32'd0, 4'b0010, 1'b1, 4'd7);

        // ---- rr unchanged by single grants: port 0 wins contention ----
        set0(1'b1, 32'hFFFF_FFF9, 32'd2, 3'd3, 4'd8);      // -7 / 2
        set1(1'b1, 32'd1, 32'd1, 3'd0, 4'd10);
        #1 chk_rdy("div", 1'b1, 1'b0);
        tick();
        chk_res("div", 1'b1, 32'hFFFF_FFFD, 4'b0001, 1'b0, 4'd8);
        chk_err("div", 1'b0);
        #1 chk_rdy("add2", 1'b0, 1'b1);
        tick();
        chk_res("add2", 1'b1, 32'd2, 4'b0000, 1'b1, 4'd10);

        // ---- divide by zero ----
        set1(1'b0, 32'd0, 32'd0, 3'd0, 4'd0);
        set0(1'b1, 32'd9, 32'd0, 3'd3, 4'd11);
        #1 chk_rdy("div0", 1'b1, 1'b0);
        tick();
        chk("div0.valid", {31'd0, res_valid}, 32'd1);
`ifdef ALU_DIVZERO_TRAP_EN
        chk("div0.data", res_data, 32'd0);
        chk("div0.flags", {28'd0, res_flags}, 32'h2);
        chk_err("div0", 1'b1);
`else
        chk_err("div0", 1'b0);
`endif
        set0(1'b1, 32'hFFFF_FFF9, 32'd2, 3'd7, 4'd12);     // -7 % 2
        tick();
        chk_res("mod", 1'b1, 32'hFFFF_FFFF, 4'b0001, 1'b0, 4'd12);
        chk_err("mod", 1'b0);

        // ---- reset mid-stream ----
        // contended grant to port 0 moves rr to 1, then block the output
        set0(1'b1, 32'd6, 32'd3, 3'd4, 4'd13);
        set1(1'b1, 32'd1, 32'd2, 3'd5, 4'd14);
        tick();
        chk_res("pre_rst", 1'b1, 32'd2, 4'b0000, 1'b0, 4'd13);
        res_ready = 1'b0;
        rst = 1'b1;
        #1 chk_rdy("rst_mid", 1'b0, 1'b0);
        tick();
        chk_res("rst_mid", 1'b0, 32'd0, 4'b0000, 1'b0, 4'd0);
        chk_err("rst_mid", 1'b0);
        rst = 1'b0;
        res_ready = 1'b1;
        #1 chk_rdy("post_rst", 1'b1, 1'b0);
        tick();
        chk_res("post_rst", 1'b1, 32'd2, 4'b0000, 1'b0, 4'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares one combinational ALU instance between two requesters, for example the integer issue slot and the address/branch helper. It accepts operand/opcode requests over valid/ready handshakes and grants the ALU round-robin. It registers the result and the V/C/Z/S flags in a single output stage, and returns them over a valid/ready result channel tagged with the source port. Sits between the issue logic and the writeback/flag register.

## Interface
- TAG_W, default 4: width of the opaque tag carried from request to result.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 granted this cycle.
- req0_a, req0_b  in  32 each  port 0 signed operands.
- req0_op  in  3  port 0 opcode: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 mod.
- req0_tag  in  TAG_W  port 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_tag: same as port 0, for port 1.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts result.
- res_data  out  32  signed result, low 32 bits.
- res_flags  out  4  {V,C,Z,S} as produced by the ALU for that operation.
- res_src  out  1  granted port (0/1).
- res_tag  out  TAG_W  tag of the granted request.
- res_err  out  1  divide/modulo by zero (see Configuration).

## Operation
- Internal ALU sees the muxed operands/opcode of the granted port; when no grant, it sees port-0 inputs (don't care).
- can_accept = !res_valid || res_ready.
- Priority pointer rr (1 bit) selects the preferred port when both are valid.
- Grant logic is combinational:
  - grant0 = can_accept & req0_valid & (!req1_valid | rr==0).
  - grant1 = can_accept & req1_valid & (!req0_valid | rr==1).
  - At most one grant per cycle.
- reqN_ready = grantN. Ready may depend on valid; requesters must not make valid depend on ready.
- On a grant, the output register loads data, flags, src, tag and err, and res_valid <= 1.
- No grant and res_ready & res_valid: res_valid <= 0. Other fields hold.
- rr update: only when both ports were valid and a grant occurred, rr <= ~granted port. Single-requester grants leave rr unchanged.
- Requester must hold a, b, op and tag stable while valid && !ready. A dropped request (valid deasserted before ready) is legal and simply not served.
- Arithmetic: 32-bit two's complement, wrap-around. mul keeps low 32 bits. div/mod use signed truncation toward zero. Flags are valid per the ALU rules: V and C are meaningful only for op 0/1, and are 0 for other ops.

## Timing
- Latency: 1 cycle. A request granted in cycle n shows on res_* from cycle n+1.
- Throughput: 1 result/cycle while res_ready = 1. Back-to-back same-cycle drain and refill is allowed (res_valid stays 1, data updates).
- Backpressure: res_valid & !res_ready gives no grants, and res_* hold stable.
- Reset values (rst high at an edge): res_valid 0, res_data 0, res_flags 0, res_src 0, res_tag 0, res_err 0, rr 0. While rst is high, req0_ready = req1_ready = 0.
- Reset mid-operation: a pending result is discarded, with no handshake completion. A request presented in a reset cycle is not granted.
- Both ports valid with output blocked: neither is granted, and rr does not change.

## Configuration
- ALU_DIVZERO_TRAP_EN defined:
  - op 3 or 7 with b == 0 sets res_err = 1, res_data = 0, res_flags = 4'b0010 (Z set).
  - The ALU divide result is ignored.
- Not defined:
  - res_err is tied 0.
  - res_data and res_flags are whatever the ALU produces, which is undefined for divide by zero. The bench must not check them in that case.

## Test plan
- Reset then idle: after rst, all res_* are 0 and both readies are 0 during rst → req0 add 5+7 grants in 1 cycle, and the next cycle res_data=12, flags=4'b0000, src=0.
- Contention: both valid every cycle with res_ready=1, port 0 sub 3-3 and port 1 add 0x7FFFFFFF+1 → grants alternate 0,1,0,1. Port 0 result 0 with Z=1. Port 1 result 0x80000000 with V=1, S=1.
- Backpressure: res_ready=0 for 3 cycles with a result held → res_* stable, no readies asserted, rr unchanged. Releasing res_ready gives a same-cycle refill.
- Single requester: port 1 alone issues 4 ops (mul -3*4, and, or, xor) → all granted back-to-back, rr stays 0, mul result 0xFFFFFFF4.
- Divide by zero with ALU_DIVZERO_TRAP_EN: div 9/0 → res_err=1, res_data=0, flags=4'b0010. Then div -7/2 → -3, and mod -7/2 → -1, both with err=0.
- Reset mid-stream: assert rst while res_valid=1 and both requests valid → next cycle res_valid=0, rr=0. After release, port 0 wins first.
